mmio_bridge_n: RTL and testbench
================================

Name: mmio_bridge_n

Overview:
- Parametrised successor to the CPU data-bus bridge.
- Routes one CPU load/store per transaction to one of N_SLV memory-mapped slaves (DM, timers, interrupt generator, future devices), selected by a parametrised base/limit map.
- Slaves answer through a req/ack handshake with variable latency. The bridge stalls the CPU until completion.
- Reports decode misses, illegal partial writes and slave timeouts as a bus error, which the CP0 exception logic consumes.

Parameters:
- N_SLV, 4, number of slave slots (1..8).
- SLV_BASE, {32'h7f20,32'h7f10,32'h7f00,32'h0000}, packed N_SLV×32 inclusive base addresses; slot i is bits [32i+31:32i].
- SLV_LIMIT, {32'h7f23,32'h7f1b,32'h7f0b,32'h2fff}, packed N_SLV×32 inclusive limit addresses.
- SLV_WORD_ONLY, 4'b0110, per-slot bit; 1 = only byteen 4'b1111 writes are legal.
- TIMEOUT, 15, maximum cycles spent in BUSY before a timeout error (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  transaction request; held high until cpu_done.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_byteen  in  4  write byte enables; 4'b0000 = read.
- cpu_rdata  out  32  read data, valid when cpu_done.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done; transaction failed.
- cpu_stall  out  1  CPU pipeline freeze.
- s_req  out  N_SLV  one-hot slave request.
- s_addr  out  32  registered address, shared by all slaves.
- s_wdata  out  32  registered write data, shared.
- s_byteen  out  4  registered byte enables, shared; forced 0 for reads.
- s_ack  in  N_SLV  slave acknowledge, sampled only for the selected slot.
- s_rdata  in  N_SLV*32  packed slave read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, capture registers 0.
- Decode is combinational on cpu_addr. hit[i] = SLV_BASE[i] <= addr <= SLV_LIMIT[i]. If several slots overlap, the lowest-index slot wins.
- States: IDLE, BUSY, RESP.
- IDLE, cpu_req=1, no hit → RESP with err=1. No s_req is raised.
- IDLE, cpu_req=1, hit, write with byteen≠4'b1111 to a SLV_WORD_ONLY slot → RESP with err=1. No s_req is raised.
- IDLE, cpu_req=1, legal hit → BUSY. On the transition edge the bridge:
  - registers s_addr, s_wdata, s_byteen and the slot index;
  - loads the counter with 0;
  - raises s_req[slot] from the next cycle.
- BUSY: s_req[slot]=1 and s_addr/s_wdata/s_byteen are held stable.
  - s_ack[slot]=1 → capture s_rdata[slot] for reads (0 for writes), err=0 → RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no ack → RESP with err=1 and rdata=0. s_req drops on that edge.
  - If ack and the timeout arrive in the same cycle, ack wins.
  - Acks on non-selected slots are ignored.
- RESP: cpu_done=1 for exactly one cycle; cpu_rdata and cpu_err are driven from the registers. Next state is always IDLE. cpu_req is not sampled in RESP, so back-to-back requests cost one bubble.
- cpu_stall = cpu_req & ~cpu_done in IDLE/BUSY, and 0 in RESP.
- Latency:
  - zero-wait slave (ack in the first BUSY cycle): cpu_done 2 cycles after the request cycle;
  - error: cpu_done 1 cycle after the request cycle;
  - timeout: cpu_done TIMEOUT+1 cycles after the request cycle.
- cpu_req dropping mid-transaction is illegal; the bridge still completes the transaction.
- Reset asserted in any state returns to IDLE next edge, clears s_req immediately, and discards the transaction. No cpu_done is issued for it.
- Unaligned addresses are the CPU's responsibility. The bridge passes addr[1:0] through unchanged.

Decomposition:
- Shared package mmio_pkg holds:
  - state encoding constants ST_IDLE/ST_BUSY/ST_RESP;
  - default address-map localparams (DM, TC0, TC1, IG);
  - the error-cause constants MISS/ILLEGAL_WR/TIMEOUT.
- One sub-module, mmio_addr_decode:
  - inputs: addr, byteen;
  - outputs: one-hot hit, slot index, legal flag;
  - purely combinational, so the map logic can be unit-tested.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
- Read slot 0 at 32'h0000_0100; slave acks in the first BUSY cycle with 32'hDEAD_BEEF → cpu_done on cycle 2, cpu_rdata=32'hDEAD_BEEF, err=0, s_req[0] high exactly 1 cycle.
- Write 32'h1234_5678, byteen 4'b1111, to 32'h7f04; ack after 3 wait cycles → s_addr/s_wdata stable all 4 BUSY cycles, s_byteen=4'b1111, cpu_done cycle 5, err=0.
- Write with byteen 4'b0011 to 32'h7f10 (word-only slot) → no s_req, cpu_done cycle 1, err=1; same write to 32'h0000_0010 succeeds.
- Read 32'h7f30 (unmapped) → cpu_done cycle 1, err=1, rdata=0; read 32'h7f1b (limit boundary) → hit slot 2.
- Slave never acks, TIMEOUT=15 → s_req high 15 cycles, cpu_done cycle 16, err=1. Then assert ack and timeout together in a second run → err=0 and data captured.
- Assert reset during BUSY → s_req=0 and state IDLE on the next edge, no cpu_done. A new request is then served normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state encoding, default address map and error causes for the MMIO bridge.
package mmio_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [31:0] DM_BASE   = 32'h0000_0000;
   localparam logic [31:0] DM_LIMIT  = 32'h0000_2fff;
   localparam logic [31:0] TC0_BASE  = 32'h0000_7f00;
   localparam logic [31:0] TC0_LIMIT = 32'h0000_7f0b;
   localparam logic [31:0] TC1_BASE  = 32'h0000_7f10;
   localparam logic [31:0] TC1_LIMIT = 32'h0000_7f1b;
   localparam logic [31:0] IG_BASE   = 32'h0000_7f20;
   localparam logic [31:0] IG_LIMIT  = 32'h0000_7f23;
   localparam logic [127:0] DEF_BASE  = {IG_BASE, TC1_BASE, TC0_BASE, DM_BASE};
   localparam logic [127:0] DEF_LIMIT = {IG_LIMIT, TC1_LIMIT, TC0_LIMIT, DM_LIMIT};
   localparam logic [3:0] DEF_WORD_ONLY = 4'b0110;
   localparam logic [1:0] ERR_MISS       = 2'd1;
   localparam logic [1:0] ERR_ILLEGAL_WR = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT    = 2'd3;
endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational base/limit slot decode with lowest-index priority and write legality.
module mmio_addr_decode import mmio_pkg::*; #(
   parameter int N_SLV = 4,
   parameter logic [32*N_SLV-1:0] SLV_BASE = DEF_BASE,
   parameter logic [32*N_SLV-1:0] SLV_LIMIT = DEF_LIMIT,
   parameter logic [N_SLV-1:0] SLV_WORD_ONLY = DEF_WORD_ONLY
) (
   input  logic [31:0]      addr,
   input  logic [3:0]       byteen,
   output logic [N_SLV-1:0] hit,
   output logic [2:0]       slot,
   output logic             legal
);
   logic [N_SLV-1:0] raw;
   logic found, word_only;
   // unsigned offset compare: addr in [base, limit] iff addr-base <= limit-base
   for (genvar i = 0; i < N_SLV; i++) begin : g_hit
      assign raw[i] = (addr - SLV_BASE[32*i +: 32]) <= (SLV_LIMIT[32*i +: 32] - SLV_BASE[32*i +: 32]);
   end
   always_comb begin
      hit = '0;
      slot = '0;
      found = 1'b0;
      word_only = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (raw[i] && !found) begin
            hit[i] = 1'b1;
            slot = 3'(i);
            word_only = SLV_WORD_ONLY[i];
            found = 1'b1;
         end
      end
      legal = found && !(word_only && byteen != 4'b0000 && byteen != 4'b1111);
   end
endmodule

// File: rtl/mmio_bridge_n.sv
// mmio_bridge_n: routes one CPU load/store to a memory-mapped slave via req/ack, stalling the CPU
// until the slave answers, and flags decode misses, illegal partial writes and timeouts as bus errors.
module mmio_bridge_n import mmio_pkg::*; #(
   parameter int N_SLV = 4,
   parameter logic [32*N_SLV-1:0] SLV_BASE = DEF_BASE,
   parameter logic [32*N_SLV-1:0] SLV_LIMIT = DEF_LIMIT,
   parameter logic [N_SLV-1:0] SLV_WORD_ONLY = DEF_WORD_ONLY,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic [31:0]          cpu_addr,
   input  logic [31:0]          cpu_wdata,
   input  logic [3:0]           cpu_byteen,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_done,
   output logic                 cpu_err,
   output logic                 cpu_stall,
   output logic [N_SLV-1:0]     s_req,
   output logic [31:0]          s_addr,
   output logic [31:0]          s_wdata,
   output logic [3:0]           s_byteen,
   input  logic [N_SLV-1:0]     s_ack,
   input  logic [32*N_SLV-1:0]  s_rdata
);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [1:0] state;
   logic [7:0] cnt;
   logic [2:0] slot_q, slot;
   logic [N_SLV-1:0] req_q, hit;
   logic [31:0] rdata_q, rsel;
   logic err_q, legal, ack;
   mmio_addr_decode #(
      .N_SLV(N_SLV), .SLV_BASE(SLV_BASE), .SLV_LIMIT(SLV_LIMIT), .SLV_WORD_ONLY(SLV_WORD_ONLY)
   ) u_dec (
      .addr(cpu_addr), .byteen(cpu_byteen), .hit(hit), .slot(slot), .legal(legal)
   );
   always_comb begin
      rsel = '0;
      for (int i = 0; i < N_SLV; i++) rsel = (slot_q == 3'(i)) ? s_rdata[32*i +: 32] : rsel;
   end
   assign ack = |(s_ack & req_q);
   assign s_req = req_q & {N_SLV{~reset}};
   assign cpu_done = state == ST_RESP;
   assign cpu_err = cpu_done & err_q;
   assign cpu_rdata = cpu_done ? rdata_q : '0;
   assign cpu_stall = cpu_req & (state != ST_RESP);
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt <= '0;
         slot_q <= '0;
         req_q <= '0;
         s_addr <= '0;
         s_wdata <= '0;
         s_byteen <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (cpu_req) begin
               if (legal) begin
                  state <= ST_BUSY;
                  s_addr <= cpu_addr;
                  s_wdata <= cpu_wdata;
                  s_byteen <= cpu_byteen;
                  slot_q <= slot;
                  cnt <= '0;
                  req_q <= hit;
               end else begin
                  state <= ST_RESP;
                  err_q <= 1'b1;
                  rdata_q <= '0;
               end
            end
            ST_BUSY: if (ack) begin
               state <= ST_RESP;
               req_q <= '0;
               err_q <= 1'b0;
               rdata_q <= |s_byteen ? '0 : rsel;
            end else if (cnt == TO_LAST) begin
               state <= ST_RESP;
               req_q <= '0;
               err_q <= 1'b1;
               rdata_q <= '0;
            end else cnt <= cnt + 8'd1;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_bridge_n.sv
// tb_mmio_bridge_n: directed checks of decode, handshake latency, errors, timeout and reset abort.
module tb_mmio_bridge_n;
   logic clk = 0, reset = 1, cpu_req = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata, s_addr, s_wdata;
   logic [3:0] cpu_byteen = 0, s_byteen, s_req, s_ack = 0;
   logic cpu_done, cpu_err, cpu_stall;
   logic [127:0] s_rdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hDEAD_BEEF};
   int checks = 0, failures = 0;
   int dc, rc;
   logic er, st, s1;
   logic [31:0] rd;
   logic [3:0] rs;
   mmio_bridge_n dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_byteen(cpu_byteen), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
      .cpu_stall(cpu_stall), .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
      .s_ack(s_ack), .s_rdata(s_rdata)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                          input int ack_cyc, input logic [3:0] ack_mask, input logic [3:0] noise,
                          output int done_cyc, output logic err, output logic [31:0] rdat,
                          output int req_cnt, output logic [3:0] req_seen, output logic stable,
                          output logic stall1);
      cpu_addr = addr; cpu_wdata = wdata; cpu_byteen = be; cpu_req = 1; s_ack = 0;
      done_cyc = -1; err = 0; rdat = 0; req_cnt = 0; req_seen = 0; stable = 1; stall1 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         s_ack = noise | ((k == ack_cyc) ? ack_mask : 4'b0000);
         if (k == 1) stall1 = cpu_stall;
         if (|s_req) begin
            req_cnt++;
            req_seen |= s_req;
            if (s_addr !== addr || s_wdata !== wdata || s_byteen !== be) stable = 0;
         end
         if (cpu_done) begin
            done_cyc = k; err = cpu_err; rdat = cpu_rdata;
            break;
         end
      end
      cpu_req = 0; s_ack = 0;
      @(posedge clk); #1;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sreq", 32'(s_req), 0);
      chk("rst_done", 32'(cpu_done), 0);
      chk("rst_saddr", s_addr, 0);
      chk("rst_rdata", cpu_rdata, 0);
      reset = 0;
      @(posedge clk); #1;
      run_txn(32'h0000_0100, 0, 4'b0000, 1, 4'b0001, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("rd0_cyc", 32'(dc), 2);
      chk("rd0_data", rd, 32'hDEAD_BEEF);
      chk("rd0_err", 32'(er), 0);
      chk("rd0_reqcnt", 32'(rc), 1);
      chk("rd0_slot", 32'(rs), 4'b0001);
      chk("rd0_stall", 32'(s1), 1);
      run_txn(32'h0000_7f04, 32'h1234_5678, 4'b1111, 4, 4'b0010, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("wr1_cyc", 32'(dc), 5);
      chk("wr1_err", 32'(er), 0);
      chk("wr1_reqcnt", 32'(rc), 4);
      chk("wr1_stable", 32'(st), 1);
      chk("wr1_slot", 32'(rs), 4'b0010);
      chk("wr1_rdata", rd, 0);
      run_txn(32'h0000_7f10, 32'hAAAA_5555, 4'b0011, 1, 4'b0100, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("wo_cyc", 32'(dc), 1);
      chk("wo_err", 32'(er), 1);
      chk("wo_reqcnt", 32'(rc), 0);
      run_txn(32'h0000_0010, 32'hAAAA_5555, 4'b0011, 1, 4'b0001, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("part_cyc", 32'(dc), 2);
      chk("part_err", 32'(er), 0);
      chk("part_slot", 32'(rs), 4'b0001);
      chk("part_rdata", rd, 0);
      run_txn(32'h0000_7f30, 0, 4'b0000, 1, 4'b1111, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("miss_cyc", 32'(dc), 1);
      chk("miss_err", 32'(er), 1);
      chk("miss_rdata", rd, 0);
      chk("miss_reqcnt", 32'(rc), 0);
      run_txn(32'h0000_3000, 0, 4'b0000, 1, 4'b1111, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("dmend_err", 32'(er), 1);
      run_txn(32'h0000_7f1b, 0, 4'b0000, 1, 4'b0100, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("lim_slot", 32'(rs), 4'b0100);
      chk("lim_data", rd, 32'hCAFE_0002);
      chk("lim_err", 32'(er), 0);
      run_txn(32'h0000_7f20, 0, 4'b0000, 0, 4'b0000, 4'b0111, dc, er, rd, rc, rs, st, s1);
      chk("to_reqcnt", 32'(rc), 15);
      chk("to_cyc", 32'(dc), 16);
      chk("to_err", 32'(er), 1);
      chk("to_rdata", rd, 0);
      run_txn(32'h0000_7f20, 0, 4'b0000, 15, 4'b1000, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("toack_cyc", 32'(dc), 16);
      chk("toack_err", 32'(er), 0);
      chk("toack_data", rd, 32'hCAFE_0003);
      cpu_addr = 32'h0000_0200; cpu_byteen = 0; cpu_req = 1;
      @(posedge clk); #1;
      chk("rb_sreq", 32'(s_req), 4'b0001);
      @(posedge clk); #1;
      reset = 1; cpu_req = 0;
      @(posedge clk); #1;
      chk("rb_sreq_clr", 32'(s_req), 0);
      chk("rb_done_rst", 32'(cpu_done), 0);
      reset = 0;
      rc = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         rc += int'(cpu_done) + int'(|s_req);
      end
      chk("rb_quiet", 32'(rc), 0);
      run_txn(32'h0000_0100, 0, 4'b0000, 1, 4'b0001, 4'b0000, dc, er, rd, rc, rs, st, s1);
      chk("rb_new_cyc", 32'(dc), 2);
      chk("rb_new_data", rd, 32'hDEAD_BEEF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
